// File: rtl/forward_stall_ctrl.sv
// EX-stage forwarding selects and load-use interlock for the five-stage pipeline.
// Also keeps a saturating count of the cycles in which the PC was held.
module forward_stall_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       hazard_ex,
  input  logic [3:0]       hazard_mem,
  input  logic             ex_is_load,
  input  logic             mem_ready,
  input  logic             flush,
  output logic             stall_pc,
  output logic             stall_if_id,
  output logic             bubble_id_ex,
  output logic             stall_id_ex,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {
    RUN       = 2'b00,
    LOAD_WAIT = 2'b01
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_reg, state_next;
  logic [1:0]       fwd_a_reg, fwd_a_next;
  logic [1:0]       fwd_b_reg, fwd_b_next;
  logic [CNT_W-1:0] count_reg;
  logic [1:0]       code_a, code_b;
  logic             load_use;

  // MEM codes are applied first so that a matching EX code overrides them.
  always_comb begin
    code_a = 2'b00;
    code_b = 2'b00;
    if (hazard_mem[3] && hazard_mem[2:0] == 3'b011) code_a = 2'b10;
    if (hazard_mem[3] && hazard_mem[2:0] == 3'b100) code_b = 2'b10;
    if (hazard_ex[3] && hazard_ex[2:0] == 3'b001)   code_a = 2'b01;
    if (hazard_ex[3] && hazard_ex[2:0] == 3'b010)   code_b = 2'b01;
  end

  assign load_use = (state_reg == RUN) && hazard_ex[3] && ex_is_load && !flush;

  always_comb begin
    state_next   = state_reg;
    fwd_a_next   = fwd_a_reg;
    fwd_b_next   = fwd_b_reg;
    stall_pc     = 1'b0;
    stall_if_id  = 1'b0;
    bubble_id_ex = 1'b0;
    stall_id_ex  = 1'b0;
    if (rst) begin
      state_next = RUN;
      fwd_a_next = 2'b00;
      fwd_b_next = 2'b00;
    end else if (flush) begin
      state_next = RUN;
      fwd_a_next = 2'b00;
      fwd_b_next = 2'b00;
    end else begin
      case (state_reg)
        RUN: begin
          if (load_use) begin
            stall_pc     = 1'b1;
            stall_if_id  = 1'b1;
            bubble_id_ex = 1'b1;
            fwd_a_next   = 2'b00;
            fwd_b_next   = 2'b00;
            state_next   = LOAD_WAIT;
          end else begin
            fwd_a_next = code_a;
            fwd_b_next = code_b;
          end
        end
        LOAD_WAIT: begin
          if (mem_ready) begin
            fwd_a_next = code_a;
            fwd_b_next = code_b;
            state_next = RUN;
          end else begin
            stall_pc    = 1'b1;
            stall_if_id = 1'b1;
            stall_id_ex = 1'b1;
          end
        end
        default: begin
          state_next = RUN;
          fwd_a_next = 2'b00;
          fwd_b_next = 2'b00;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= RUN;
      fwd_a_reg <= 2'b00;
      fwd_b_reg <= 2'b00;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      fwd_a_reg <= fwd_a_next;
      fwd_b_reg <= fwd_b_next;
      if (stall_pc && count_reg != CNT_MAX) count_reg <= count_reg + 1'b1;
    end
  end

  assign fwd_a_sel   = fwd_a_reg;
  assign fwd_b_sel   = fwd_b_reg;
  assign stall_count = count_reg;

endmodule

// File: tb/tb_forward_stall_ctrl.sv
// Directed bench for forward_stall_ctrl; a CNT_W=4 copy shares the stimulus for saturation.
module tb_forward_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  hazard_ex, hazard_mem;
  logic        ex_is_load, mem_ready, flush;
  logic        stall_pc, stall_if_id, bubble_id_ex, stall_id_ex;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic [15:0] stall_count;
  logic        s_stall_pc, s_stall_if_id, s_bubble_id_ex, s_stall_id_ex;
  logic [1:0]  s_fwd_a_sel, s_fwd_b_sel;
  logic [3:0]  s_stall_count;
  logic [3:0]  ctrl;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  // ctrl = {stall_pc, stall_if_id, bubble_id_ex, stall_id_ex}
  assign ctrl = {stall_pc, stall_if_id, bubble_id_ex, stall_id_ex};

  forward_stall_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .hazard_ex(hazard_ex), .hazard_mem(hazard_mem),
    .ex_is_load(ex_is_load), .mem_ready(mem_ready), .flush(flush),
    .stall_pc(stall_pc), .stall_if_id(stall_if_id), .bubble_id_ex(bubble_id_ex),
    .stall_id_ex(stall_id_ex), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .stall_count(stall_count)
  );

  forward_stall_ctrl #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .hazard_ex(hazard_ex), .hazard_mem(hazard_mem),
    .ex_is_load(ex_is_load), .mem_ready(mem_ready), .flush(flush),
    .stall_pc(s_stall_pc), .stall_if_id(s_stall_if_id), .bubble_id_ex(s_bubble_id_ex),
    .stall_id_ex(s_stall_id_ex), .fwd_a_sel(s_fwd_a_sel), .fwd_b_sel(s_fwd_b_sel),
    .stall_count(s_stall_count)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] hex, input logic [3:0] hmem,
                       input logic load, input logic mr, input logic fl);
    hazard_ex  = hex;
    hazard_mem = hmem;
    ex_is_load = load;
    mem_ready  = mr;
    flush      = fl;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(4'b1001, 4'b0000, 1'b1, 1'b0, 1'b0);
    checks++;
    if (ctrl !== 4'b0000) begin errors++; $display("FAIL reset_ctrl_comb: got %b want 0000", ctrl); end
    tick; tick;
    checks++;
    if ({ctrl, fwd_a_sel, fwd_b_sel} !== 8'h00) begin
      errors++; $display("FAIL reset_outputs: ctrl=%b a=%b b=%b want all 0", ctrl, fwd_a_sel, fwd_b_sel);
    end
    checks++;
    if (stall_count !== 16'd0 || s_stall_count !== 4'd0) begin
      errors++; $display("FAIL reset_count: got %0d/%0d want 0/0", stall_count, s_stall_count);
    end
    rst = 1'b0;
    drive(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    checks++;
    if (ctrl !== 4'b0000) begin errors++; $display("FAIL reset_state_run: ctrl=%b want 0000", ctrl); end
    $display("test_reset done");
  endtask

  task automatic test_alu_fwd;
    drive(4'b1001, 4'b1100, 1'b0, 1'b0, 1'b0);
    checks++;
    if (ctrl !== 4'b0000) begin errors++; $display("FAIL alu_no_stall: ctrl=%b want 0000", ctrl); end
    tick;
    checks++;
    if (fwd_a_sel !== 2'b01 || fwd_b_sel !== 2'b10) begin
      errors++; $display("FAIL alu_fwd: a=%b b=%b want a=01 b=10", fwd_a_sel, fwd_b_sel);
    end
    $display("test_alu_fwd a=%b b=%b", fwd_a_sel, fwd_b_sel);
  endtask

  task automatic test_ex_priority;
    drive(4'b1010, 4'b1100, 1'b0, 1'b0, 1'b0);
    tick;
    checks++;
    if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b01) begin
      errors++; $display("FAIL ex_priority: a=%b b=%b want a=00 b=01", fwd_a_sel, fwd_b_sel);
    end
    $display("test_ex_priority a=%b b=%b", fwd_a_sel, fwd_b_sel);
  endtask

  task automatic test_invalid_codes;
    // mem_ready high in RUN must be ignored
    drive(4'b1111, 4'b1000, 1'b0, 1'b1, 1'b0);
    checks++;
    if (ctrl !== 4'b0000) begin errors++; $display("FAIL invalid_no_stall: ctrl=%b want 0000", ctrl); end
    tick;
    checks++;
    if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00) begin
      errors++; $display("FAIL invalid_codes: a=%b b=%b want 00 00", fwd_a_sel, fwd_b_sel);
    end
    drive(4'b1011, 4'b1011, 1'b0, 1'b0, 1'b0);
    tick;
    checks++;
    if (fwd_a_sel !== 2'b10 || fwd_b_sel !== 2'b00) begin
      errors++; $display("FAIL invalid_ex_mem_a: a=%b b=%b want 10 00", fwd_a_sel, fwd_b_sel);
    end
    $display("test_invalid_codes a=%b b=%b", fwd_a_sel, fwd_b_sel);
  endtask

  task automatic test_load_use;
    drive(4'b1001, 4'b0000, 1'b1, 1'b0, 1'b0);
    checks++;
    if (ctrl !== 4'b1110) begin errors++; $display("FAIL lu_detect: ctrl=%b want 1110", ctrl); end
    tick;
    drive(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    checks++;
    if (ctrl !== 4'b1101) begin errors++; $display("FAIL lu_wait1: ctrl=%b want 1101", ctrl); end
    checks++;
    if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00) begin
      errors++; $display("FAIL lu_bubble_fwd: a=%b b=%b want 00 00", fwd_a_sel, fwd_b_sel);
    end
    tick;
    drive(4'b0000, 4'b1011, 1'b0, 1'b0, 1'b0);
    checks++;
    if (ctrl !== 4'b1101) begin errors++; $display("FAIL lu_wait2: ctrl=%b want 1101", ctrl); end
    tick;
    checks++;
    if (fwd_a_sel !== 2'b00) begin errors++; $display("FAIL lu_fwd_hold: a=%b want 00", fwd_a_sel); end
    drive(4'b0000, 4'b1011, 1'b0, 1'b1, 1'b0);
    checks++;
    if (ctrl !== 4'b0000) begin errors++; $display("FAIL lu_ready: ctrl=%b want 0000", ctrl); end
    tick;
    checks++;
    if (fwd_a_sel !== 2'b10 || fwd_b_sel !== 2'b00) begin
      errors++; $display("FAIL lu_fwd_mem: a=%b b=%b want 10 00", fwd_a_sel, fwd_b_sel);
    end
    checks++;
    if (stall_count !== 16'd3) begin errors++; $display("FAIL lu_count: got %0d want 3", stall_count); end
    drive(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    checks++;
    if (ctrl !== 4'b0000) begin errors++; $display("FAIL lu_back_run: ctrl=%b want 0000", ctrl); end
    tick;
    $display("test_load_use count=%0d", stall_count);
  endtask

  task automatic test_flush;
    drive(4'b1001, 4'b0000, 1'b1, 1'b0, 1'b0);
    tick;
    drive(4'b0000, 4'b1011, 1'b0, 1'b0, 1'b1);
    checks++;
    if (ctrl !== 4'b0000) begin errors++; $display("FAIL flush_wait_ctrl: ctrl=%b want 0000", ctrl); end
    tick;
    drive(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    checks++;
    if (ctrl !== 4'b0000) begin errors++; $display("FAIL flush_to_run: ctrl=%b want 0000", ctrl); end
    checks++;
    if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00) begin
      errors++; $display("FAIL flush_fwd: a=%b b=%b want 00 00", fwd_a_sel, fwd_b_sel);
    end
    checks++;
    if (stall_count !== 16'd4) begin errors++; $display("FAIL flush_count: got %0d want 4", stall_count); end
    drive(4'b1001, 4'b1100, 1'b1, 1'b0, 1'b1);
    checks++;
    if (ctrl !== 4'b0000) begin errors++; $display("FAIL flush_vs_lu: ctrl=%b want 0000", ctrl); end
    tick;
    drive(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    checks++;
    if (ctrl !== 4'b0000 || fwd_b_sel !== 2'b00 || stall_count !== 16'd4) begin
      errors++; $display("FAIL flush_vs_lu_after: ctrl=%b b=%b cnt=%0d want 0000 00 4", ctrl, fwd_b_sel, stall_count);
    end
    tick;
    $display("test_flush count=%0d", stall_count);
  endtask

  task automatic test_saturation;
    int exp_sat;
    rst = 1'b1;
    tick; tick;
    rst = 1'b0;
    drive(4'b1001, 4'b0000, 1'b1, 1'b0, 1'b0);
    tick;
    drive(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 19; i++) begin
      tick;
      exp_sat = (i + 1 > 15) ? 15 : i + 1;
      checks++;
      if (s_stall_count !== 4'(exp_sat)) begin
        errors++; $display("FAIL sat_count[%0d]: got %0d want %0d", i, s_stall_count, exp_sat);
      end
    end
    checks++;
    if (stall_count !== 16'd20) begin errors++; $display("FAIL sat_wide_count: got %0d want 20", stall_count); end
    rst = 1'b1;
    #1;
    checks++;
    if (ctrl !== 4'b0000) begin errors++; $display("FAIL rst_in_wait_comb: ctrl=%b want 0000", ctrl); end
    tick;
    rst = 1'b0;
    #1;
    checks++;
    if (ctrl !== 4'b0000 || stall_count !== 16'd0 || s_stall_count !== 4'd0) begin
      errors++; $display("FAIL rst_in_wait_after: ctrl=%b cnt=%0d/%0d want 0000 0/0", ctrl, stall_count, s_stall_count);
    end
    $display("test_saturation sat_count=%0d", s_stall_count);
  endtask

  initial begin
    test_reset();
    test_alu_fwd();
    test_ex_priority();
    test_invalid_codes();
    test_load_use();
    test_flush();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/forward_stall_ctrl.md
# forward_stall_ctrl

Consumer of the hazard codes produced by the ID-vs-EX and ID-vs-MEM hazard checks in the 32I five-stage pipeline. Converts them into registered forwarding-mux selects for the EX stage and runs the load-use interlock FSM. Drives PC/IF-ID stall, ID/EX bubble insertion and pipeline hold while a data-memory load is outstanding. Keeps a saturating stall-cycle counter for performance debug.

## Interface
Parameters:
- CNT_W, 16, width of the stall-cycle counter

Ports:
- clk  in  1  pipeline clock
- rst  in  1  reset; one clock, synchronous, active-high
- hazard_ex  in  4  {valid, code} from the ID-vs-EX check; code is `FROM_EX_RS1` = 3'b001 or `FROM_EX_RS2` = 3'b010
- hazard_mem  in  4  {valid, code} from the ID-vs-MEM check; code is `FROM_MEM_RS1` = 3'b011 or `FROM_MEM_RS2` = 3'b100
- ex_is_load  in  1  instruction in EX has opcode `LOAD`
- mem_ready  in  1  load data in MEM is valid this cycle
- flush  in  1  branch/jump redirect resolved in EX
- stall_pc  out  1  hold PC
- stall_if_id  out  1  hold IF/ID register
- bubble_id_ex  out  1  load NOP into ID/EX
- stall_id_ex  out  1  hold ID/EX and EX/MEM registers
- fwd_a_sel  out  2  EX operand A source: 00 regfile, 01 EX/MEM, 10 MEM/WB
- fwd_b_sel  out  2  EX operand B source, same encoding
- stall_count  out  CNT_W  cycles with stall_pc=1, saturating

## Operation
- FSM states: RUN (2'b00), LOAD_WAIT (2'b01). Reset state is RUN.
- Load-use condition: state==RUN && hazard_ex[3] && ex_is_load && !flush.
- RUN with no load-use:
  - All stall and bubble outputs are 0.
  - The next fwd select comes from the hazard codes.
  - A code of 001 or 010 sets the matching operand to 01.
  - A code of 011 or 100 sets the matching operand to 10, unless that operand already gets 01 from hazard_ex (EX result is younger and wins).
  - An operand with no hazard gets 00.
  - An invalid code (valid=1 with an undefined value) is treated as no hazard.
- RUN with load-use:
  - stall_pc=1, stall_if_id=1, bubble_id_ex=1, stall_id_ex=0.
  - Next fwd selects are 00 (bubble enters EX).
  - Next state is LOAD_WAIT.
- LOAD_WAIT with mem_ready=0:
  - stall_pc=1, stall_if_id=1, stall_id_ex=1, bubble_id_ex=0.
  - fwd selects hold; state holds.
- LOAD_WAIT with mem_ready=1:
  - All stall and bubble outputs are 0.
  - fwd selects load from the hazard codes as in RUN. The load now sits in MEM, so the expected select is 10.
  - Next state is RUN. No new load-use check is made in this cycle.
- flush=1 has the highest priority in any state:
  - All stall and bubble outputs are 0.
  - Next fwd selects are 00.
  - Next state is RUN.
- stall_count increments by 1 in every cycle where stall_pc=1. It holds at 2^CNT_W-1 once reached. It is cleared only by rst.

## Timing
- Stall, bubble and hold outputs are combinational (Mealy) from the current state and inputs, valid in the same cycle.
- fwd_a_sel and fwd_b_sel are registered and update on the rising edge. They are consumed in the cycle after the ID-stage instruction advances into EX.
- fwd selects update only when stall_id_ex=0.
- Load-use latency: detection at cycle T, then LOAD_WAIT from T+1.
  - With mem_ready=1 at T+1: the dependent instruction is in EX at T+2 with select 10.
  - Each cycle of mem_ready=0 adds one stall cycle.
- Reset values: state RUN, fwd_a_sel=00, fwd_b_sel=00, stall_count=0, all stall and bubble outputs 0 (rst forces them to 0 combinationally as well).
- rst during LOAD_WAIT returns to RUN on the next edge with all registers cleared.
- flush together with load-use in the same cycle: no stall; flush wins.
- mem_ready is ignored in RUN.

## Test plan
- Reset: hold rst 2 cycles with hazard_ex=4'b1001, ex_is_load=1 -> all outputs 0, stall_count=0, state RUN.
- ALU forwarding: hazard_ex=4'b1001, hazard_mem=4'b1100, ex_is_load=0 -> no stall; next edge fwd_a_sel=01, fwd_b_sel=10.
- EX priority: hazard_ex=4'b1010, hazard_mem=4'b1100 -> next edge fwd_b_sel=01, fwd_a_sel=00.
- Load-use with 2-cycle memory:
  - Stimulus: hazard_ex=4'b1001 with ex_is_load=1 at T, mem_ready=0 at T+1..T+2, mem_ready=1 with hazard_mem=4'b1011 at T+3.
  - Response: at T stall_pc=1 and bubble_id_ex=1; at T+1..T+2 stall_pc=1 and stall_id_ex=1; at T+3 no stall; after T+3 fwd_a_sel=10 and stall_count=3.
- Flush: flush=1 in LOAD_WAIT with mem_ready=0 -> stall outputs 0 in that cycle; next edge state RUN and fwd selects 00.
- Saturation: CNT_W=4, 20 consecutive stall cycles -> stall_count stops at 4'hF and never wraps.
